// File: rtl/riscv_pkg.sv
// ============================================================================
//  Module   : riscv_pkg
//  Purpose  : Shared enums for the unified memory port arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE     = 2'd0,
    ARB_WAIT_GNT = 2'd1,
    ARB_BUSY     = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } arb_owner_e;

endpackage

`default_nettype wire

// File: rtl/arb_starve_ctr.sv
// ============================================================================
//  Module   : arb_starve_ctr
//  Purpose  : Saturating count of D grants taken while I waits; flags when I
//             must be given priority.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module arb_starve_ctr #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_req_i,
  input  logic i_gnt_i,
  input  logic d_gnt_i,
  output logic force_i_o
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_gnt_i) begin
      cnt_d = '0;
    end else if (d_gnt_i && i_req_i && (cnt_q != c_cnt_max)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign force_i_o = i_req_i && (cnt_q == c_cnt_max);

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Shares one memory port between fetch (I) and load/store (D),
//             D-first priority, one outstanding transaction. Define
//             ARB_STARVE_GUARD_EN to build the I starvation guard.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
  import riscv_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                m_req,
  output logic                m_we,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_be,
  input  logic                m_gnt,
  input  logic                m_rvalid,
  input  logic [DATA_W-1:0]   m_rdata
);

  arb_state_e state_q, state_d;
  arb_owner_e owner_q, owner_d;
  arb_owner_e sel_owner;
  logic       force_i;
  logic       rsp_fire;

`ifdef ARB_STARVE_GUARD_EN
  arb_starve_ctr #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve_ctr (
    .clk       (clk),
    .rst       (rst),
    .i_req_i   (i_req),
    .i_gnt_i   (i_gnt),
    .d_gnt_i   (d_gnt),
    .force_i_o (force_i)
  );
`else
  logic unused_starve_max;
  assign unused_starve_max = (STARVE_MAX > 0);
  assign force_i           = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    sel_owner = OWN_NONE;
    m_we      = 1'b0;
    m_addr    = '0;
    m_wdata   = '0;
    m_be      = '0;

    // Once a request is presented it stays locked to that owner until granted.
    case (state_q)
      ARB_IDLE: begin
        if (d_req && !force_i) sel_owner = OWN_D;
        else if (i_req)        sel_owner = OWN_I;
      end
      ARB_WAIT_GNT: sel_owner = owner_q;
      default:      sel_owner = OWN_NONE;
    endcase

    m_req    = !rst && (sel_owner != OWN_NONE);
    i_gnt    = m_req && m_gnt && (sel_owner == OWN_I);
    d_gnt    = m_req && m_gnt && (sel_owner == OWN_D);
    rsp_fire = !rst && (state_q == ARB_BUSY) && m_rvalid;
    i_rvalid = rsp_fire && (owner_q == OWN_I);
    d_rvalid = rsp_fire && (owner_q == OWN_D);
    i_rdata  = i_rvalid ? m_rdata : '0;
    d_rdata  = d_rvalid ? m_rdata : '0;

    if (m_req && (sel_owner == OWN_I)) begin
      m_addr = i_addr;
      m_be   = '1;
    end else if (m_req && (sel_owner == OWN_D)) begin
      m_we    = d_we;
      m_addr  = d_addr;
      m_wdata = d_wdata;
      m_be    = d_be;
    end

    case (state_q)
      ARB_IDLE: begin
        if (m_req) begin
          owner_d = sel_owner;
          state_d = m_gnt ? ARB_BUSY : ARB_WAIT_GNT;
        end
      end
      ARB_WAIT_GNT: begin
        if (m_gnt) state_d = ARB_BUSY;
      end
      ARB_BUSY: begin
        if (m_rvalid) begin
          state_d = ARB_IDLE;
          owner_d = OWN_NONE;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        owner_d = OWN_NONE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      owner_q <= OWN_NONE;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
//  Module   : tb_mem_port_arbiter
//  Purpose  : Directed scenarios plus randomized traffic against a
//             transaction-level model of the arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

  localparam int STARVE_MAX = 4;
  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              i_req, d_req, d_we, m_gnt, m_rvalid;
  logic [ADDR_W-1:0] i_addr, d_addr;
  logic [DATA_W-1:0] d_wdata, m_rdata;
  logic [3:0]        d_be;
  logic              i_gnt, i_rvalid, d_gnt, d_rvalid, m_req, m_we;
  logic [DATA_W-1:0] i_rdata, d_rdata, m_wdata;
  logic [ADDR_W-1:0] m_addr;
  logic [3:0]        m_be;
  logic [137:0]      all_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign all_o = {m_req, m_we, m_addr, m_wdata, m_be, i_gnt, d_gnt,
                  i_rvalid, d_rvalid, i_rdata, d_rdata};

  mem_port_arbiter #(
    .STARVE_MAX (STARVE_MAX),
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_gnt    (i_gnt),
    .i_rvalid (i_rvalid),
    .i_rdata  (i_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_be     (d_be),
    .d_gnt    (d_gnt),
    .d_rvalid (d_rvalid),
    .d_rdata  (d_rdata),
    .m_req    (m_req),
    .m_we     (m_we),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_be     (m_be),
    .m_gnt    (m_gnt),
    .m_rvalid (m_rvalid),
    .m_rdata  (m_rdata)
  );

  task automatic drive_idle();
    i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0;
    d_wdata = '0; d_be = '0; m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
  endtask

  // I held, D held, memory always ready with one-cycle latency.
  task automatic run_starve(output int nd, output bit gi);
    bit busy;
    nd = 0; gi = 1'b0; busy = 1'b0;
    i_req = 1'b1; i_addr = 32'h500; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h6000;
    for (int k = 0; k < 30 && !gi; k++) begin
      @(negedge clk);
      m_gnt = 1'b1; m_rvalid = busy; m_rdata = $urandom;
      #1;
      if (d_gnt) nd++;
      if (i_gnt) gi = 1'b1;
      busy = i_gnt | d_gnt;
    end
    @(negedge clk);
    i_req = 1'b0; d_req = 1'b0; m_gnt = 1'b0; m_rvalid = busy;
    @(negedge clk);
    m_rvalid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    drive_idle(); rst = 1'b1;
    @(negedge clk);
    i_req = 1'b1; d_req = 1'b1; i_addr = 32'h10; d_addr = 32'h20; d_we = 1'b1;
    d_wdata = '1; d_be = '1; m_gnt = 1'b1; m_rvalid = 1'b1; m_rdata = '1;
    #1;
    total++; if (all_o !== '0) begin bad++; $display("FAIL reset_outputs got=%h exp=0", all_o); end
    @(negedge clk);
    drive_idle(); rst = 1'b0;
    #1;
    total++; if (all_o !== '0) begin bad++; $display("FAIL after_reset got=%h exp=0", all_o); end
  endtask

  task automatic test_single_fetch();
    @(negedge clk);
    drive_idle(); i_req = 1'b1; i_addr = 32'h100; m_gnt = 1'b1;
    #1;
    total++; if ({m_req, i_gnt, d_gnt, m_we} !== 4'b1100) begin bad++; $display("FAIL fetch_gnt got=%b exp=1100", {m_req, i_gnt, d_gnt, m_we}); end
    total++; if (m_addr !== 32'h100) begin bad++; $display("FAIL fetch_addr got=%h exp=100", m_addr); end
    @(negedge clk);
    i_req = 1'b0; m_gnt = 1'b0;
    #1;
    total++; if ({m_req, i_rvalid, d_rvalid} !== 3'b000) begin bad++; $display("FAIL fetch_busy got=%b exp=000", {m_req, i_rvalid, d_rvalid}); end
    @(negedge clk);
    m_rvalid = 1'b1; m_rdata = 32'h00500093;
    #1;
    total++; if ({i_rvalid, d_rvalid, i_rdata} !== {2'b10, 32'h00500093}) begin bad++; $display("FAIL fetch_resp got=%b%b %h exp=10 00500093", i_rvalid, d_rvalid, i_rdata); end
    @(negedge clk);
    m_rvalid = 1'b0;
    #1;
    total++; if ({i_rvalid, d_rvalid} !== 2'b00) begin bad++; $display("FAIL fetch_pulse got=%b exp=00", {i_rvalid, d_rvalid}); end
  endtask

  task automatic test_priority();
    @(negedge clk);
    drive_idle(); i_req = 1'b1; i_addr = 32'h104; d_req = 1'b1; d_addr = 32'h2000; m_gnt = 1'b1;
    #1;
    total++; if ({i_gnt, d_gnt, m_addr} !== {2'b01, 32'h2000}) begin bad++; $display("FAIL prio_d_first got=%b%b %h exp=01 2000", i_gnt, d_gnt, m_addr); end
    @(negedge clk);
    d_req = 1'b0; m_rvalid = 1'b1; m_rdata = 32'hCAFE0001;
    #1;
    total++; if ({d_rvalid, d_rdata, i_gnt, m_req} !== {1'b1, 32'hCAFE0001, 2'b00}) begin bad++; $display("FAIL prio_d_resp got=%b %h %b%b exp=1 cafe0001 00", d_rvalid, d_rdata, i_gnt, m_req); end
    @(negedge clk);
    m_rvalid = 1'b0;
    #1;
    total++; if ({i_gnt, d_gnt, m_addr} !== {2'b10, 32'h104}) begin bad++; $display("FAIL prio_i_next got=%b%b %h exp=10 104", i_gnt, d_gnt, m_addr); end
    @(negedge clk);
    i_req = 1'b0; m_gnt = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h11112222;
    #1;
    total++; if ({i_rvalid, d_rvalid, i_rdata} !== {2'b10, 32'h11112222}) begin bad++; $display("FAIL prio_i_resp got=%b%b %h exp=10 11112222", i_rvalid, d_rvalid, i_rdata); end
  endtask

  task automatic test_lock();
    @(negedge clk);
    drive_idle(); i_req = 1'b1; i_addr = 32'h200;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) begin d_req = 1'b1; d_addr = 32'h3000; end
      #1;
      total++; if ({m_req, i_gnt, d_gnt, m_addr} !== {3'b100, 32'h200}) begin bad++; $display("FAIL lock_hold c=%0d got=%b%b%b %h exp=100 200", c, m_req, i_gnt, d_gnt, m_addr); end
      @(negedge clk);
    end
    m_gnt = 1'b1;
    #1;
    total++; if ({i_gnt, d_gnt, m_addr} !== {2'b10, 32'h200}) begin bad++; $display("FAIL lock_gnt got=%b%b %h exp=10 200", i_gnt, d_gnt, m_addr); end
    @(negedge clk);
    i_req = 1'b0; m_gnt = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h5A5A5A5A;
    #1;
    total++; if ({i_rvalid, i_rdata, d_gnt, m_req} !== {1'b1, 32'h5A5A5A5A, 2'b00}) begin bad++; $display("FAIL lock_resp got=%b %h %b%b exp=1 5a5a5a5a 00", i_rvalid, i_rdata, d_gnt, m_req); end
    @(negedge clk);
    m_rvalid = 1'b0; m_gnt = 1'b1;
    #1;
    total++; if ({d_gnt, m_addr} !== {1'b1, 32'h3000}) begin bad++; $display("FAIL lock_d_after got=%b %h exp=1 3000", d_gnt, m_addr); end
    @(negedge clk);
    d_req = 1'b0; m_gnt = 1'b0; m_rvalid = 1'b1;
    #1;
    total++; if (d_rvalid !== 1'b1) begin bad++; $display("FAIL lock_d_resp got=%b exp=1", d_rvalid); end
    @(negedge clk);
    m_rvalid = 1'b0;
  endtask

  task automatic test_store();
    @(negedge clk);
    drive_idle(); d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_wdata = 32'hDEADBEEF; d_addr = 32'h40; m_gnt = 1'b1;
    #1;
    total++; if ({d_gnt, m_we, m_be, m_wdata, m_addr} !== {2'b11, 4'b0011, 32'hDEADBEEF, 32'h40}) begin bad++; $display("FAIL store_attr got=%b%b %b %h %h exp=11 0011 deadbeef 40", d_gnt, m_we, m_be, m_wdata, m_addr); end
    @(negedge clk);
    d_req = 1'b0; m_gnt = 1'b0; m_rvalid = 1'b1;
    #1;
    total++; if ({d_rvalid, i_rvalid} !== 2'b10) begin bad++; $display("FAIL store_ack got=%b exp=10", {d_rvalid, i_rvalid}); end
    @(negedge clk);
    m_rvalid = 1'b0;
  endtask

  task automatic test_starvation();
    int nd; bit gi;
    @(negedge clk);
    drive_idle();
    run_starve(nd, gi);
`ifdef ARB_STARVE_GUARD_EN
    total++; if (nd != STARVE_MAX || !gi) begin bad++; $display("FAIL starve_guard got d=%0d i=%0b exp d=%0d i=1", nd, gi, STARVE_MAX); end
`else
    total++; if (gi || nd != 15) begin bad++; $display("FAIL starve_fixed got d=%0d i=%0b exp d=15 i=0", nd, gi); end
`endif
  endtask

  task automatic test_reset_busy();
    int ng; bit busy; int nd; bit gi;
    @(negedge clk);
    drive_idle();
    i_req = 1'b1; i_addr = 32'h700; d_req = 1'b1; d_addr = 32'h7000;
    ng = 0; busy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      m_gnt = 1'b1; m_rvalid = busy;
      #1;
      if (d_gnt) ng++;
      busy = d_gnt | i_gnt;
    end
    total++; if (ng != 3) begin bad++; $display("FAIL rstbusy_pre got=%0d exp=3", ng); end
    @(negedge clk);
    rst = 1'b1; i_req = 1'b0; d_req = 1'b0; m_gnt = 1'b0; m_rvalid = 1'b0;
    #1;
    total++; if (all_o !== '0) begin bad++; $display("FAIL rstbusy_during got=%h exp=0", all_o); end
    @(negedge clk);
    rst = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h1234;
    #1;
    total++; if (all_o !== '0) begin bad++; $display("FAIL rstbusy_drop got=%h exp=0", all_o); end
    @(negedge clk);
    m_rvalid = 1'b0;
    run_starve(nd, gi);
`ifdef ARB_STARVE_GUARD_EN
    total++; if (nd != STARVE_MAX || !gi) begin bad++; $display("FAIL rstbusy_cnt got d=%0d i=%0b exp d=%0d i=1", nd, gi, STARVE_MAX); end
`else
    total++; if (gi) begin bad++; $display("FAIL rstbusy_fixed got i=%0b exp i=0", gi); end
`endif
  endtask

  task automatic test_random();
    bit ip = 1'b0, dp = 1'b0, ov = 1'b0;
    int lat = 0, lock = 0, cnt = 0, own = 0, oo = 0;
    logic [DATA_W-1:0] od = '0;
    logic eig, edg, eir, edr;
    @(negedge clk);
    drive_idle();
    for (int c = 0; c < 3000; c++) begin
      if (c > 0) @(negedge clk);
      if (!ip && $urandom_range(1, 0) == 1) begin ip = 1'b1; i_addr = $urandom; end
      if (!dp && $urandom_range(1, 0) == 1) begin
        dp = 1'b1; d_we = 1'($urandom_range(1, 0)); d_addr = $urandom;
        d_wdata = $urandom; d_be = 4'($urandom_range(15, 0));
      end
      i_req = ip; d_req = dp;
      m_gnt = ($urandom_range(9, 0) < 6);
      if (ov) begin
        m_rvalid = (lat == 0);
        if (lat > 0) lat--;
      end else begin
        m_rvalid = ($urandom_range(4, 0) == 0);
      end
      m_rdata = $urandom;
      if (ov && m_rvalid) od = m_rdata;
      own = 0;
      if (!ov && (ip || dp)) begin
        if (lock != 0) own = lock;
        else if (dp && !(GUARD && ip && cnt == STARVE_MAX)) own = 2;
        else own = 1;
      end
      eig = m_gnt && (own == 1);
      edg = m_gnt && (own == 2);
      eir = ov && m_rvalid && (oo == 1);
      edr = ov && m_rvalid && (oo == 2);
      #1;
      total++; if ({m_req, i_gnt, d_gnt, i_rvalid, d_rvalid} !== {(own != 0), eig, edg, eir, edr}) begin bad++; $display("FAIL rnd_ctrl c=%0d got=%b exp=%b", c, {m_req, i_gnt, d_gnt, i_rvalid, d_rvalid}, {(own != 0), eig, edg, eir, edr}); end
      if (own == 1) begin
        total++; if ({m_we, m_addr, m_wdata} !== {1'b0, i_addr, 32'h0}) begin bad++; $display("FAIL rnd_i_attr c=%0d got=%b %h %h exp=0 %h 0", c, m_we, m_addr, m_wdata, i_addr); end
      end else if (own == 2) begin
        total++; if ({m_we, m_addr, m_wdata, m_be} !== {d_we, d_addr, d_wdata, d_be}) begin bad++; $display("FAIL rnd_d_attr c=%0d got=%b %h %h %b exp=%b %h %h %b", c, m_we, m_addr, m_wdata, m_be, d_we, d_addr, d_wdata, d_be); end
      end else begin
        total++; if ({m_we, m_addr, m_wdata, m_be} !== '0) begin bad++; $display("FAIL rnd_idle_attr c=%0d got=%b %h %h %b exp=0", c, m_we, m_addr, m_wdata, m_be); end
      end
      if (eir) begin
        total++; if (i_rdata !== od) begin bad++; $display("FAIL rnd_i_rdata c=%0d got=%h exp=%h", c, i_rdata, od); end
      end
      if (edr) begin
        total++; if (d_rdata !== od) begin bad++; $display("FAIL rnd_d_rdata c=%0d got=%h exp=%h", c, d_rdata, od); end
      end
      if (eig || edg) begin
        ov = 1'b1; oo = own; lat = $urandom_range(2, 0); lock = 0;
        if (eig) begin ip = 1'b0; cnt = 0; end
        else begin
          dp = 1'b0;
          if (ip && cnt < STARVE_MAX) cnt++;
        end
      end else if (own != 0) begin
        lock = own;
      end
      if (eir || edr) ov = 1'b0;
    end
    @(negedge clk);
    drive_idle(); rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    drive_idle();
    rst = 1'b1;
    test_reset();
    test_single_fetch();
    test_priority();
    test_lock();
    test_store();
    test_starvation();
    test_reset_busy();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single unified memory port between the instruction-fetch requester (I) and the load/store requester (D) of the RISC-V core, as the step from split instruction/data memories to one memory. It arbitrates with fixed data-over-fetch priority and an optional starvation guard. It keeps at most one transaction outstanding and routes each response back to the requester that issued it.

## Interface
- STARVE_MAX, 4: consecutive D grants made while I is pending before I is forced to win (≥1); used only when the guard is compiled in
- ADDR_W, 32: address width
- DATA_W, 32: data width
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- i_req  in  1  fetch request, held with i_addr until i_gnt
- i_addr  in  ADDR_W  fetch address
- i_gnt  out  1  fetch request accepted this cycle
- i_rvalid  out  1  fetch data valid (one-cycle pulse)
- i_rdata  out  DATA_W  fetch data
- d_req  in  1  load/store request, attributes held until d_gnt
- d_we  in  1  1 = store
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_be  in  DATA_W/8  byte enables
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  load data / store ack valid (one-cycle pulse)
- d_rdata  out  DATA_W  load data
- m_req  out  1  memory request
- m_we, m_addr, m_wdata, m_be  out  1/ADDR_W/DATA_W/DATA_W/8  memory attributes
- m_gnt  in  1  memory accepts m_req this cycle
- m_rvalid  in  1  memory response (for both reads and writes), earliest one cycle after m_gnt
- m_rdata  in  DATA_W  memory read data

## Operation
- States: IDLE, WAIT_GNT, BUSY. An owner register (NONE/I/D) is held alongside.
- IDLE: if either request is present, select an owner. D wins, unless the guard forces I. Drive m_req=1 with the owner's attributes. If m_gnt is high, go to BUSY; otherwise go to WAIT_GNT.
- WAIT_GNT: the owner is locked. m_req and the attributes track the locked owner only, and a newly arriving higher-priority request does not preempt it. Go to BUSY on m_gnt.
- Grant rule: i_gnt = m_gnt & m_req & (owner==I); d_gnt is defined the same way for D. The grant is combinational in the same cycle as m_gnt.
- BUSY: m_req=0. On m_rvalid, pulse the owner's rvalid and pass m_rdata through combinationally. The other requester's rvalid stays 0 and its rdata is don't-care. Then go to IDLE and set owner to NONE.
- In IDLE and WAIT_GNT, i_rvalid and d_rvalid are 0. An m_rvalid in IDLE is dropped.
- Unselected attribute outputs are 0 when m_req=0.
- Starvation counter:
  - Increments on a D grant while i_req=1.
  - Clears on any I grant.
  - Saturates at STARVE_MAX.
  - When it equals STARVE_MAX and i_req=1, I has priority in IDLE.
- Requester withdrawing req before grant: not permitted (protocol error; behaviour undefined, no checking).

## Timing
- Reset values: state IDLE, owner NONE, counter 0. All outputs 0: m_req, m_we, m_addr, m_wdata, m_be, i_gnt, d_gnt, i_rvalid, d_rvalid, i_rdata, d_rdata.
- Reset during WAIT_GNT or BUSY aborts the transaction: next cycle is IDLE and no rvalid is delivered.
- Request to grant: 0 cycles when memory is ready (request and grant in the same cycle as IDLE).
- After rvalid, the next grant is at earliest the following cycle. Back-to-back throughput is therefore one transaction per (memory latency + 1) cycles.
- Simultaneous i_req and d_req in IDLE: D is granted, I waits.
- rst has priority over every other event in the same cycle.

## Configuration
- ARB_STARVE_GUARD_EN defined: the starvation counter and the STARVE_MAX forcing are built.
- Not defined: pure fixed priority with D always winning. No counter flops exist, and STARVE_MAX is ignored.

## Structure
- Shared package riscv_pkg: the arb_state_e enum (IDLE/WAIT_GNT/BUSY) and the arb_owner_e enum (NONE/I/D).
- One sub-module, arb_starve_ctr: the saturating counter plus force flag. It is instantiated only under ARB_STARVE_GUARD_EN.

## Test plan
- Single fetch: i_req, i_addr=0x100, memory ready with rvalid 2 cycles later and rdata=0x00500093 -> i_gnt in cycle 0, m_addr=0x100, i_rvalid pulse with i_rdata=0x00500093, d_rvalid=0.
- Simultaneous i_req (0x104) and d_req load (0x2000) -> D granted first. The I grant comes in the cycle after d_rvalid.
- Lock: m_gnt held low 3 cycles with I selected, d_req rises in cycle 1 -> m_addr stays at i_addr, I granted when m_gnt rises, no preemption.
- Starvation, with the guard built and STARVE_MAX=4: i_req held, d_req continuous -> 4 D grants, then the I grant. With the guard not built -> I is never granted while d_req is held.
- Store: d_we=1, d_be=4'b0011, d_wdata=0xDEADBEEF -> m_we=1, m_be=4'b0011, d_rvalid ack.
- Reset in BUSY, then m_rvalid in the next cycle -> no rvalid output, state IDLE, counter 0.
